// File: rtl/secded_decoder.sv
// secded_decoder: reads extended Hamming (16,11) code words from data memory,
// corrects single-bit errors, flags double-bit errors and writes the 11-bit
// messages back with a 2-bit status in the top bits of the high byte.
//
// Memory handshake: there is no valid/ready pair. A read is a combinational
// lookup, so mem_rdata belongs to the mem_addr shown in the same cycle and is
// sampled on the edge that ends RD_LO or RD_HI. A write happens on every
// rising edge where mem_we is high, using mem_addr/mem_wdata from that cycle.
module secded_decoder #(
   parameter int SRC_BASE  = 30,
   parameter int DST_BASE  = 0,
   parameter int NUM_WORDS = 15
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rdata,
   output logic       mem_we,
   output logic [7:0] mem_wdata,
   output logic       done,
   output logic [6:0] err1_cnt,
   output logic [6:0] err2_cnt,
   output logic [2:0] state_dbg
);

   localparam logic [7:0] SRC_B    = 8'(SRC_BASE);
   localparam logic [7:0] DST_B    = 8'(DST_BASE);
   localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);
   localparam logic [6:0] CNT_MAX  = 7'd127;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      DEC   = 3'd3,
      WR_LO = 3'd4,
      WR_HI = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t      state, state_nx;
   logic [5:0]  idx;
   logic [7:0]  lo_reg, hi_reg;
   logic [7:0]  out_lo, out_hi;

   logic [15:0] word;
   logic [3:0]  syn;
   logic        par;
   logic [1:0]  flags;
   logic [15:0] flip_mask;
   logic [15:0] fixed;
   logic [7:0]  byte_off;

   assign state_dbg = state;

   // Byte offset of word idx inside its source or destination region.
   assign byte_off = {1'b0, idx, 1'b0};

   // State register; reset returns to IDLE and release starts a run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic for the per-word read/decode/write sequence.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = RD_LO;
         RD_LO:   state_nx = RD_HI;
         RD_HI:   state_nx = DEC;
         DEC:     state_nx = WR_LO;
         WR_LO:   state_nx = WR_HI;
         WR_HI:   state_nx = (idx == LAST_IDX) ? DONE : RD_LO;
         DONE:    state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   // Word index: cleared in IDLE, advanced after the high byte is written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                  idx <= '0;
      else if (state == IDLE)                     idx <= '0;
      else if (state == WR_HI && idx != LAST_IDX) idx <= idx + 6'd1;
   end

   // Syndrome, overall parity, classification and correction of the held word.
   // Each syndrome bit is the parity of the positions whose index has that bit set.
   always_comb begin
      word      = {hi_reg, lo_reg};
      syn[0]    = ^(word & 16'hAAAA);
      syn[1]    = ^(word & 16'hCCCC);
      syn[2]    = ^(word & 16'hF0F0);
      syn[3]    = ^(word & 16'hFF00);
      par       = ^word;
      flags     = 2'b00;
      flip_mask = '0;
      if (par) begin
         flags = 2'b01;
         if (syn != 4'd0) flip_mask = 16'd1 << syn;
      end else if (syn != 4'd0) begin
         flags = 2'b10;
      end
      fixed = word ^ flip_mask;
   end

   // Capture the two code bytes, then register the decoded bytes in DEC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lo_reg <= '0;
         hi_reg <= '0;
         out_lo <= '0;
         out_hi <= '0;
      end else begin
         if (state == RD_LO) lo_reg <= mem_rdata;
         if (state == RD_HI) hi_reg <= mem_rdata;
         if (state == DEC) begin
            out_lo <= {fixed[12], fixed[11], fixed[10], fixed[9],
                       fixed[7],  fixed[6],  fixed[5],  fixed[3]};
            out_hi <= {flags, 3'b000, fixed[15], fixed[14], fixed[13]};
         end
      end
   end

   // Saturating error counters, bumped once per classified word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err1_cnt <= '0;
         err2_cnt <= '0;
      end else if (state == DEC) begin
         if (flags == 2'b01 && err1_cnt != CNT_MAX) err1_cnt <= err1_cnt + 7'd1;
         if (flags == 2'b10 && err2_cnt != CNT_MAX) err2_cnt <= err2_cnt + 7'd1;
      end
   end

   // Memory port and done decode purely from state, so reset clears them at once.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      done      = 1'b0;
      case (state)
         RD_LO: mem_addr = SRC_B + byte_off;
         RD_HI: mem_addr = SRC_B + byte_off + 8'd1;
         DEC:   mem_addr = SRC_B + byte_off + 8'd1;
         WR_LO: begin
            mem_we    = 1'b1;
            mem_addr  = DST_B + byte_off;
            mem_wdata = out_lo;
         end
         WR_HI: begin
            mem_we    = 1'b1;
            mem_addr  = DST_B + byte_off + 8'd1;
            mem_wdata = out_hi;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_secded_decoder.sv
// Bench for secded_decoder: a default-parameter instance (A) and an in-place
// instance (B), each with its own byte memory and reset.
module tb_secded_decoder;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_a = 1'b1;
   logic reset_b = 1'b1;

   // ---------------- instance A (SRC 30, DST 0, 15 words) ----------------
   logic [7:0] addr_a, rdata_a, wdata_a;
   logic       we_a, done_a;
   logic [6:0] e1_a, e2_a;
   logic [2:0] st_a;
   logic [7:0] mem_a [256];

   secded_decoder dut_a (
      .clk(clk), .reset(reset_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
      .mem_we(we_a), .mem_wdata(wdata_a), .done(done_a),
      .err1_cnt(e1_a), .err2_cnt(e2_a), .state_dbg(st_a)
   );

   assign rdata_a = mem_a[addr_a];
   int we_cnt_a = 0;
   always @(posedge clk) begin
      if (we_a) begin
         mem_a[addr_a] <= wdata_a;
         we_cnt_a = we_cnt_a + 1;
      end
   end

   // ---------------- instance B (in place at 0) ----------------
   logic [7:0] addr_b, rdata_b, wdata_b;
   logic       we_b, done_b;
   logic [6:0] e1_b, e2_b;
   logic [2:0] st_b;
   logic [7:0] mem_b [256];

   secded_decoder #(.SRC_BASE(0), .DST_BASE(0), .NUM_WORDS(15)) dut_b (
      .clk(clk), .reset(reset_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
      .mem_we(we_b), .mem_wdata(wdata_b), .done(done_b),
      .err1_cnt(e1_b), .err2_cnt(e2_b), .state_dbg(st_b)
   );

   assign rdata_b = mem_b[addr_b];
   int we_cnt_b = 0;
   always @(posedge clk) begin
      if (we_b) begin
         mem_b[addr_b] <= wdata_b;
         we_cnt_b = we_cnt_b + 1;
      end
   end

   // ---------------- scoreboard state ----------------
   int tests = 0;
   int fails = 0;
   logic [15:0] exp_q[$];
   int exp_e1, exp_e2;
   logic [15:0] codes [15];

   typedef struct {
      logic [15:0] code;
      logic [7:0]  lo;
      logic [7:0]  hi;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Hamming positions that are not powers of two carry data, in order.
   function automatic logic [15:0] ref_encode(input logic [10:0] msg);
      logic [15:0] w;
      int j, c;
      w = '0;
      j = 0;
      for (int k = 1; k < 16; k++) begin
         if ((k & (k - 1)) != 0) begin
            w[k] = msg[j];
            j++;
         end
      end
      for (int p = 1; p < 16; p = p * 2) begin
         c = 0;
         for (int k = 1; k < 16; k++) if ((k & p) != 0 && w[k]) c++;
         w[p] = (c % 2) == 1;
      end
      w[0] = ($countones(w) % 2) == 1;
      return w;
   endfunction

   // Returns {hi, lo} of the decoded output word.
   function automatic logic [15:0] ref_decode(input logic [15:0] w_in);
      logic [15:0] w;
      logic [10:0] msg;
      logic [1:0]  fl;
      int s, ones, j;
      w = w_in;
      s = 0;
      ones = 0;
      for (int k = 0; k < 16; k++) begin
         if (w[k]) begin
            ones++;
            s = s ^ k;
         end
      end
      if (ones % 2 == 1) begin
         fl = 2'b01;
         if (s != 0) w[s] = ~w[s];
      end else if (s != 0) fl = 2'b10;
      else fl = 2'b00;
      msg = '0;
      j = 0;
      for (int k = 1; k < 16; k++) begin
         if ((k & (k - 1)) != 0) begin
            msg[j] = w[k];
            j++;
         end
      end
      return {fl, 3'b000, msg[10:8], msg[7:0]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic load_a();
      for (int i = 0; i < 15; i++) begin
         mem_a[30 + 2*i]     = codes[i][7:0];
         mem_a[30 + 2*i + 1] = codes[i][15:8];
         mem_a[2*i]          = 8'hEE;
         mem_a[2*i + 1]      = 8'hEE;
      end
   endtask

   task automatic load_b();
      for (int i = 0; i < 15; i++) begin
         mem_b[2*i]     = codes[i][7:0];
         mem_b[2*i + 1] = codes[i][15:8];
      end
   endtask

   task automatic expect_model();
      logic [15:0] d;
      exp_q.delete();
      exp_e1 = 0;
      exp_e2 = 0;
      for (int i = 0; i < 15; i++) begin
         d = ref_decode(codes[i]);
         exp_q.push_back(d);
         if (d[15:14] == 2'b01) exp_e1++;
         if (d[15:14] == 2'b10) exp_e2++;
      end
   endtask

   task automatic random_codes();
      int nerr, b1, b2;
      for (int i = 0; i < 15; i++) begin
         codes[i] = ref_encode(11'($urandom_range(0, 2047)));
         nerr = $urandom_range(0, 2);
         b1 = $urandom_range(0, 15);
         b2 = (b1 + $urandom_range(1, 15)) % 16;
         if (nerr >= 1) codes[i][b1] = ~codes[i][b1];
         if (nerr == 2) codes[i][b2] = ~codes[i][b2];
      end
   endtask

   // Release reset on a falling edge and count rising edges until done.
   task automatic run_a(input string tag);
      int de;
      reset_a = 1'b1;
      repeat (2) @(negedge clk);
      we_cnt_a = 0;
      reset_a = 1'b0;
      de = -1;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         if (done_a) begin
            de = k;
            break;
         end
      end
      check($sformatf("%s done_edge", tag), de, 76);
      check($sformatf("%s we_pulses", tag), we_cnt_a, 30);
   endtask

   task automatic run_b(input string tag);
      int de;
      reset_b = 1'b1;
      repeat (2) @(negedge clk);
      we_cnt_b = 0;
      reset_b = 1'b0;
      de = -1;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         if (done_b) begin
            de = k;
            break;
         end
      end
      check($sformatf("%s done_edge", tag), de, 76);
      check($sformatf("%s we_pulses", tag), we_cnt_b, 30);
   endtask

   task automatic score_a(input string tag);
      logic [15:0] d;
      for (int i = 0; i < 15; i++) begin
         d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
         check($sformatf("%s w%0d lo", tag, i), int'(mem_a[2*i]), int'(d[7:0]));
         check($sformatf("%s w%0d hi", tag, i), int'(mem_a[2*i + 1]), int'(d[15:8]));
      end
      check($sformatf("%s err1_cnt", tag), int'(e1_a), exp_e1);
      check($sformatf("%s err2_cnt", tag), int'(e2_a), exp_e2);
   endtask

   task automatic score_b(input string tag);
      logic [15:0] d;
      for (int i = 0; i < 15; i++) begin
         d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
         check($sformatf("%s w%0d lo", tag, i), int'(mem_b[2*i]), int'(d[7:0]));
         check($sformatf("%s w%0d hi", tag, i), int'(mem_b[2*i + 1]), int'(d[15:8]));
      end
      check($sformatf("%s err1_cnt", tag), int'(e1_b), exp_e1);
      check($sformatf("%s err2_cnt", tag), int'(e2_b), exp_e2);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vec_t tbl[5];
      tbl[0] = '{16'hB42D, 8'hA3, 8'h05};   // clean
      tbl[1] = '{16'hB02D, 8'hA3, 8'h45};   // bit 10 flipped
      tbl[2] = '{16'hB42C, 8'hA3, 8'h45};   // p0 flipped
      tbl[3] = '{16'hB025, 8'h82, 8'h85};   // bits 10 and 3 flipped
      tbl[4] = '{16'h342D, 8'hA3, 8'h45};   // bit 15 flipped

      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end

      // Reset state
      repeat (2) @(negedge clk);
      check("reset done", int'(done_a), 0);
      check("reset mem_we", int'(we_a), 0);
      check("reset mem_addr", int'(addr_a), 0);
      check("reset mem_wdata", int'(wdata_a), 0);
      check("reset err1", int'(e1_a), 0);
      check("reset err2", int'(e2_a), 0);

      // Table-driven vectors: table words first, remaining words clean
      exp_q.delete();
      exp_e1 = 0;
      exp_e2 = 0;
      for (int i = 0; i < 15; i++) begin
         if (i < 5) begin
            codes[i] = tbl[i].code;
            exp_q.push_back({tbl[i].hi, tbl[i].lo});
            if (tbl[i].hi[7:6] == 2'b01) exp_e1++;
            if (tbl[i].hi[7:6] == 2'b10) exp_e2++;
         end else begin
            codes[i] = 16'hB42D;
            exp_q.push_back(16'h05A3);
         end
      end
      load_a();
      run_a("table");
      score_a("table");

      // Every single-bit flip of 16'hB42D, across two runs
      exp_q.delete();
      for (int i = 0; i < 15; i++) begin
         codes[i] = 16'hB42D ^ (16'd1 << i);
         exp_q.push_back(16'h45A3);
      end
      exp_e1 = 15;
      exp_e2 = 0;
      load_a();
      run_a("flip0_14");
      score_a("flip0_14");

      exp_q.delete();
      codes[0] = 16'hB42D ^ 16'h8000;
      exp_q.push_back(16'h45A3);
      for (int i = 1; i < 15; i++) begin
         codes[i] = 16'hB42D;
         exp_q.push_back(16'h05A3);
      end
      exp_e1 = 1;
      exp_e2 = 0;
      load_a();
      run_a("flip15");
      score_a("flip15");

      // Randomized full runs against the reference model
      for (int r = 0; r < 3; r++) begin
         random_codes();
         expect_model();
         load_a();
         run_a($sformatf("rand%0d", r));
         score_a($sformatf("rand%0d", r));
      end

      // Reset during word 7 WR_LO, then a clean restart
      random_codes();
      expect_model();
      load_a();
      reset_a = 1'b1;
      @(negedge clk);
      reset_a = 1'b0;
      repeat (39) @(posedge clk);
      #1;
      check("midrst we before", int'(we_a), 1);
      check("midrst addr before", int'(addr_a), 14);
      check("midrst wdata before", int'(wdata_a), int'(exp_q[7][7:0]));
      #2;
      reset_a = 1'b1;
      #1;
      check("midrst we", int'(we_a), 0);
      check("midrst addr", int'(addr_a), 0);
      check("midrst wdata", int'(wdata_a), 0);
      check("midrst done", int'(done_a), 0);
      check("midrst err1", int'(e1_a), 0);
      check("midrst err2", int'(e2_a), 0);
      repeat (3) @(posedge clk);
      #1;
      check("midrst w7 lo untouched", int'(mem_a[14]), 8'hEE);
      check("midrst w7 hi untouched", int'(mem_a[15]), 8'hEE);
      run_a("midrst rerun");
      score_a("midrst rerun");

      // In-place decode on instance B
      random_codes();
      expect_model();
      load_b();
      run_b("inplace");
      score_b("inplace");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
